// File: rtl/ct_f_spsram_acc_ctrl_pkg.sv
// Shared types and defaults for the single-port SRAM access controller and its
// response buffer.
package ct_f_spsram_acc_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 196;
  localparam int DEF_DEPTH      = 256;
  localparam int RSP_BUF_DEPTH  = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/ct_f_spsram_acc_ctrl_rsp_buf.sv
// Two-entry response FIFO with 1-bit wrap pointers; the head entry is always
// presented, so the consumer reads it directly from a register.
module ct_f_spsram_rsp_buf
  import ct_f_spsram_acc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            cnt
);

  logic [DATA_WIDTH-1:0] mem_q [RSP_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_BUF_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign cnt       = cnt_q;

endmodule

// File: rtl/ct_f_spsram_acc_ctrl.sv
// Initiator-side controller for a single-port SRAM macro (active-low CEN/GWEN/WEN).
// Optional zero-fill after reset is built when SPSRAM_ACC_CTRL_INIT_EN is defined.
module ct_f_spsram_acc_ctrl
  import ct_f_spsram_acc_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wen_b,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_WIDTH");
  end

`ifdef SPSRAM_ACC_CTRL_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`else
  localparam state_e RST_STATE = ST_READY;
`endif

  state_e                state_q, state_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                  buf_empty, buf_push, buf_pop;
  logic                  credit_ok, accept;

  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
`ifdef SPSRAM_ACC_CTRL_INIT_EN
    init_cnt_d  = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
      if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d     = ST_READY;
        init_done_d = 1'b1;
      end
    end
`else
    init_done_d = 1'b1;
`endif
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q       <= RST_STATE;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
`ifdef SPSRAM_ACC_CTRL_INIT_EN
      init_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      init_done_q   <= init_done_d;
      rd_inflight_q <= rd_inflight_d;
`ifdef SPSRAM_ACC_CTRL_INIT_EN
      init_cnt_q    <= init_cnt_d;
`endif
    end
  end

  // Reads need a buffer credit; writes return nothing and always pass once ready.
  assign credit_ok     = (buf_cnt + {1'b0, rd_inflight_q}) < 2'(RSP_BUF_DEPTH);
  assign req_rdy       = cpurst_b && (state_q == ST_READY) && (req_wr || credit_ok);
  assign accept        = req_vld && req_rdy;
  assign rd_inflight_d = accept && !req_wr;
  assign init_done     = init_done_q;

  // Inflight read data bypasses an empty buffer so it is visible one cycle after accept.
  assign buf_empty = (buf_cnt == 2'd0);
  assign buf_pop   = rsp_rdy && !buf_empty;
  assign buf_push  = rd_inflight_q && !(buf_empty && rsp_rdy);
  assign rsp_vld   = !buf_empty || rd_inflight_q;
  assign rsp_rdata = (buf_empty && rd_inflight_q) ? sram_q : buf_head;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
`ifdef SPSRAM_ACC_CTRL_INIT_EN
    if (cpurst_b && (state_q == ST_INIT)) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
    end else
`endif
    if (accept) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = req_wen_b;
        sram_d    = req_wdata;
      end
    end
  end

  ct_f_spsram_rsp_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buf (
    .clk       (forever_cpuclk),
    .rst_b     (cpurst_b),
    .push      (buf_push),
    .push_data (sram_q),
    .pop       (buf_pop),
    .head_data (buf_head),
    .cnt       (buf_cnt)
  );

endmodule
